// File: rtl/uart_loader.sv
// ---------------------------------------------------------------------------
// uart_loader
//
// Program loader between a UART receiver and an instruction memory write
// port. It parses a frame of
//     SYNC_BYTE, LEN_LO, LEN_HI, N*DATA_BYTES data bytes, CSUM
// assembles little-endian words, writes them to consecutive addresses
// starting at 0, and checks an 8-bit modulo-256 sum of the data bytes.
// The core is held in reset (cpu_hold) until a frame completes cleanly.
//
// Ports
//   clk           system clock (single domain)
//   reset         synchronous, active-high reset
//   rx_dv         one-cycle strobe: rx_byte is valid
//   rx_byte       received byte
//   mem_we        one-cycle write strobe to instruction memory
//   mem_addr      write address
//   mem_wdata     write data (8*DATA_BYTES bits)
//   cpu_hold      holds the core in reset while high
//   busy          frame in progress (LEN_LO, LEN_HI, DATA, CHECK)
//   done          last frame completed with a good checksum
//   error         last frame aborted
//   err_code      0 none, 1 length, 2 timeout, 3 checksum
//   words_loaded  words written in the current or last frame
// ---------------------------------------------------------------------------
module uart_loader #(
    parameter int          DATA_BYTES   = 4,
    parameter int          ADDR_WIDTH   = 8,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          TIMEOUT_CLKS = 2_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx_dv,
    input  logic [7:0]                rx_byte,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [8*DATA_BYTES-1:0]   mem_wdata,
    output logic                      cpu_hold,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [1:0]                err_code,
    output logic [ADDR_WIDTH:0]       words_loaded
);

    localparam int WORD_W = 8 * DATA_BYTES;
    localparam int IDX_W  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int TO_W   = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CLKS - 1);

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_LEN   = 2'd1;
    localparam logic [1:0] ERR_TOUT  = 2'd2;
    localparam logic [1:0] ERR_CSUM  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                  state_q,        state_d;
    logic [7:0]              len_lo_q,       len_lo_d;
    logic [15:0]             len_q,          len_d;
    logic [IDX_W-1:0]        byte_idx_q,     byte_idx_d;
    logic [WORD_W-1:0]       word_q,         word_d;
    logic [7:0]              csum_q,         csum_d;
    logic [ADDR_WIDTH-1:0]   addr_q,         addr_d;
    logic [TO_W-1:0]         idle_q,         idle_d;
    logic                    mem_we_q,       mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q,     mem_addr_d;
    logic [WORD_W-1:0]       mem_wdata_q,    mem_wdata_d;
    logic                    cpu_hold_q,     cpu_hold_d;
    logic                    busy_q,         busy_d;
    logic                    done_q,         done_d;
    logic                    error_q,        error_d;
    logic [1:0]              err_code_q,     err_code_d;
    logic [ADDR_WIDTH:0]     words_loaded_q, words_loaded_d;

    // Word with the incoming byte dropped into lane byte_idx_q.
    logic [WORD_W-1:0] word_ins;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
            assign word_ins[8*gi +: 8] =
                (byte_idx_q == IDX_W'(gi)) ? rx_byte : word_q[8*gi +: 8];
        end
    endgenerate

    logic [15:0] len_full;
    logic        len_too_long;
    logic        last_word;
    logic        in_frame;

    assign len_full     = {rx_byte, len_lo_q};
    // N == 2^ADDR_WIDTH fills memory exactly and is legal.
    assign len_too_long = 32'(len_full) > (32'd1 << ADDR_WIDTH);
    assign last_word    = (32'(words_loaded_q) + 32'd1) == 32'(len_q);
    assign in_frame     = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                          (state_q == S_DATA)   || (state_q == S_CHECK);

    always_comb begin
        state_d        = state_q;
        len_lo_d       = len_lo_q;
        len_d          = len_q;
        byte_idx_d     = byte_idx_q;
        word_d         = word_q;
        csum_d         = csum_q;
        addr_d         = addr_q;
        idle_d         = idle_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        cpu_hold_d     = cpu_hold_q;
        done_d         = done_q;
        error_d        = error_q;
        err_code_d     = err_code_q;
        words_loaded_d = words_loaded_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (rx_dv && (rx_byte == SYNC_BYTE)) begin
                    state_d        = S_LEN_LO;
                    words_loaded_d = '0;
                    addr_d         = '0;
                    byte_idx_d     = '0;
                    word_d         = '0;
                    csum_d         = '0;
                    done_d         = 1'b0;
                    error_d        = 1'b0;
                    err_code_d     = ERR_NONE;
                    cpu_hold_d     = 1'b1;
                end
            end

            S_LEN_LO: begin
                if (rx_dv) begin
                    len_lo_d = rx_byte;
                    state_d  = S_LEN_HI;
                end
            end

            S_LEN_HI: begin
                if (rx_dv) begin
                    len_d = len_full;
                    if (len_too_long) begin
                        state_d    = S_ERROR;
                        error_d    = 1'b1;
                        err_code_d = ERR_LEN;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (rx_dv) begin
                    csum_d = csum_q + rx_byte;
                    word_d = word_ins;
                    if (byte_idx_q == LAST_IDX) begin
                        mem_we_d       = 1'b1;
                        mem_addr_d     = addr_q;
                        mem_wdata_d    = word_ins;
                        addr_d         = addr_q + 1'b1;
                        words_loaded_d = words_loaded_q + 1'b1;
                        byte_idx_d     = '0;
                        if (last_word) begin
                            state_d = S_CHECK;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end

            S_CHECK: begin
                if (rx_dv) begin
                    if (rx_byte == csum_q) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d    = S_ERROR;
                        error_d    = 1'b1;
                        err_code_d = ERR_CSUM;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Inter-byte timeout. A strobe in the expiring cycle wins because
        // the counter only fires when rx_dv is low.
        if (in_frame) begin
            if (rx_dv) begin
                idle_d = '0;
            end else if (idle_q == TO_LAST) begin
                state_d    = S_ERROR;
                error_d    = 1'b1;
                err_code_d = ERR_TOUT;
                idle_d     = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end

        if (state_d != state_q) begin
            idle_d = '0;
        end

        busy_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                 (state_d == S_DATA)   || (state_d == S_CHECK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            len_lo_q       <= '0;
            len_q          <= '0;
            byte_idx_q     <= '0;
            word_q         <= '0;
            csum_q         <= '0;
            addr_q         <= '0;
            idle_q         <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            cpu_hold_q     <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            err_code_q     <= ERR_NONE;
            words_loaded_q <= '0;
        end else begin
            state_q        <= state_d;
            len_lo_q       <= len_lo_d;
            len_q          <= len_d;
            byte_idx_q     <= byte_idx_d;
            word_q         <= word_d;
            csum_q         <= csum_d;
            addr_q         <= addr_d;
            idle_q         <= idle_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            cpu_hold_q     <= cpu_hold_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
            err_code_q     <= err_code_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_code     = err_code_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_uart_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_loader
//
// Directed bench for uart_loader (DATA_BYTES=4, ADDR_WIDTH=8,
// TIMEOUT_CLKS=64). A table of whole frames with hand-computed results is
// applied in sequence, followed by hand-written sequences for the
// cycle-exact corners: reset state, length-error timing, timeout boundary,
// reset in the middle of DATA, and the N=2^ADDR_WIDTH length boundary.
// ---------------------------------------------------------------------------
module tb_uart_loader;

    logic        clk;
    logic        reset;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [8:0]  words_loaded;

    uart_loader #(
        .DATA_BYTES   (4),
        .ADDR_WIDTH   (8),
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_CLKS (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_dv        (rx_dv),
        .rx_byte      (rx_byte),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Every cycle with mem_we high is logged, so a stretched strobe shows up
    // as an extra write.
    logic [7:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            $display("write  addr=%0d data=%08h", mem_addr, mem_wdata);
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Strobe one byte for one cycle, then idle for 'gap' cycles.
    task automatic drive_byte(input logic [7:0] b, input int gap);
        rx_dv   = 1'b1;
        rx_byte = b;
        cycle();
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        for (int g = 0; g < gap; g++) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    typedef struct {
        string        name;
        logic [127:0] bytes;   // frame, right-aligned, first byte leftmost
        int           nb;
        int           gap;
        int           idle;
        logic         e_done;
        logic         e_err;
        logic [1:0]   e_code;
        logic         e_hold;
        logic [8:0]   e_wl;
        int           e_nw;
        logic [7:0]   a0;
        logic [31:0]  d0;
        logic [7:0]   a1;
        logic [31:0]  d1;
    } vec_t;

    vec_t vecs[7];

    task automatic set_vec(input int i, input string name,
                           input logic [127:0] bytes, input int nb,
                           input int gap, input int idle,
                           input logic e_done, input logic e_err,
                           input logic [1:0] e_code, input logic e_hold,
                           input logic [8:0] e_wl, input int e_nw,
                           input logic [7:0] a0, input logic [31:0] d0,
                           input logic [7:0] a1, input logic [31:0] d1);
        vecs[i].name   = name;
        vecs[i].bytes  = bytes;
        vecs[i].nb     = nb;
        vecs[i].gap    = gap;
        vecs[i].idle   = idle;
        vecs[i].e_done = e_done;
        vecs[i].e_err  = e_err;
        vecs[i].e_code = e_code;
        vecs[i].e_hold = e_hold;
        vecs[i].e_wl   = e_wl;
        vecs[i].e_nw   = e_nw;
        vecs[i].a0     = a0;
        vecs[i].d0     = d0;
        vecs[i].a1     = a1;
        vecs[i].d1     = d1;
    endtask

    task automatic clear_writes();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".mem_we"},       64'(mem_we),       64'd0);
        check({tag, ".mem_addr"},     64'(mem_addr),     64'd0);
        check({tag, ".mem_wdata"},    64'(mem_wdata),    64'd0);
        check({tag, ".cpu_hold"},     64'(cpu_hold),     64'd1);
        check({tag, ".busy"},         64'(busy),         64'd0);
        check({tag, ".done"},         64'(done),         64'd0);
        check({tag, ".error"},        64'(error),        64'd0);
        check({tag, ".err_code"},     64'(err_code),     64'd0);
        check({tag, ".words_loaded"}, 64'(words_loaded), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, limit 2000000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;

        // name, bytes, nb, gap, idle, done, err, code, hold, wl, nw, a0, d0, a1, d1
        set_vec(0, "good_load", 128'hA5_02_00_13_00_00_00_93_00_10_00_B6, 12, 2, 0,
                1'b1, 1'b0, 2'd0, 1'b0, 9'd2, 2, 8'd0, 32'h00000013, 8'd1, 32'h00100093);
        set_vec(1, "bad_csum",  128'hA5_02_00_13_00_00_00_93_00_10_00_B7, 12, 1, 0,
                1'b0, 1'b1, 2'd3, 1'b1, 9'd2, 2, 8'd0, 32'h00000013, 8'd1, 32'h00100093);
        set_vec(2, "len_ovf",   128'hA5_01_01, 3, 0, 0,
                1'b0, 1'b1, 2'd1, 1'b1, 9'd0, 0, 8'd0, 32'h0, 8'd0, 32'h0);
        set_vec(3, "timeout",   128'hA5_02_00_13, 4, 0, 70,
                1'b0, 1'b1, 2'd2, 1'b1, 9'd0, 0, 8'd0, 32'h0, 8'd0, 32'h0);
        set_vec(4, "recovery",  128'hA5_02_00_13_00_00_00_93_00_10_00_B6, 12, 0, 0,
                1'b1, 1'b0, 2'd0, 1'b0, 9'd2, 2, 8'd0, 32'h00000013, 8'd1, 32'h00100093);
        set_vec(5, "noise_a5",  128'h00_FF_5A_A5_01_00_A5_11_22_33_0B, 11, 0, 0,
                1'b1, 1'b0, 2'd0, 1'b0, 9'd1, 1, 8'd0, 32'h332211A5, 8'd0, 32'h0);
        set_vec(6, "n_zero",    128'hA5_00_00_00, 4, 0, 0,
                1'b1, 1'b0, 2'd0, 1'b0, 9'd0, 0, 8'd0, 32'h0, 8'd0, 32'h0);

        reset   = 1'b1;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        cycle();
        cycle();
        reset = 1'b0;
        check_reset_state("reset");
        $display("reset  state checked");

        // ---- table-driven frames ----
        for (int i = 0; i < 7; i++) begin
            clear_writes();
            for (int k = 0; k < vecs[i].nb; k++) begin
                b = vecs[i].bytes[8*(vecs[i].nb-1-k) +: 8];
                drive_byte(b, vecs[i].gap);
            end
            for (int w = 0; w < vecs[i].idle + 3; w++) cycle();
            check({vecs[i].name, ".done"},     64'(done),         64'(vecs[i].e_done));
            check({vecs[i].name, ".error"},    64'(error),        64'(vecs[i].e_err));
            check({vecs[i].name, ".err_code"}, 64'(err_code),     64'(vecs[i].e_code));
            check({vecs[i].name, ".cpu_hold"}, 64'(cpu_hold),     64'(vecs[i].e_hold));
            check({vecs[i].name, ".busy"},     64'(busy),         64'd0);
            check({vecs[i].name, ".words"},    64'(words_loaded), 64'(vecs[i].e_wl));
            check({vecs[i].name, ".nwrites"},  64'(wr_addr_q.size()), 64'(vecs[i].e_nw));
            if (vecs[i].e_nw > 0 && wr_addr_q.size() > 0) begin
                check({vecs[i].name, ".w0_addr"}, 64'(wr_addr_q[0]), 64'(vecs[i].a0));
                check({vecs[i].name, ".w0_data"}, 64'(wr_data_q[0]), 64'(vecs[i].d0));
            end
            if (vecs[i].e_nw > 1 && wr_addr_q.size() > 1) begin
                check({vecs[i].name, ".w1_addr"}, 64'(wr_addr_q[1]), 64'(vecs[i].a1));
                check({vecs[i].name, ".w1_data"}, 64'(wr_data_q[1]), 64'(vecs[i].d1));
            end
            $display("frame  %s: done=%0d error=%0d code=%0d hold=%0d words=%0d writes=%0d",
                     vecs[i].name, done, error, err_code, cpu_hold, words_loaded,
                     wr_addr_q.size());
        end

        // ---- length error lands exactly one cycle after the LEN_HI strobe ----
        clear_writes();
        drive_byte(8'hA5, 0);
        drive_byte(8'h01, 0);
        rx_dv   = 1'b1;
        rx_byte = 8'h01;
        #1;
        check("lenhi.error_before", 64'(error), 64'd0);
        check("lenhi.busy_before",  64'(busy),  64'd1);
        @(posedge clk);
        #1;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        check("lenhi.error_after", 64'(error),    64'd1);
        check("lenhi.code_after",  64'(err_code), 64'd1);
        check("lenhi.busy_after",  64'(busy),     64'd0);
        cycle();
        check("lenhi.nwrites", 64'(wr_addr_q.size()), 64'd0);
        $display("seq    length error timing: error=%0d code=%0d", error, err_code);

        // ---- timeout boundary: strobe in the expiring cycle, then expiry ----
        clear_writes();
        drive_byte(8'hA5, 0);
        drive_byte(8'h01, 0);
        drive_byte(8'h00, 0);
        drive_byte(8'h13, 63);
        drive_byte(8'h00, 0);
        check("tout.survive_err",  64'(error), 64'd0);
        check("tout.survive_busy", 64'(busy),  64'd1);
        drive_byte(8'h00, 0);
        drive_byte(8'h00, 63);
        check("tout.edge_err", 64'(error), 64'd0);
        cycle();
        check("tout.fire_err",  64'(error),    64'd1);
        check("tout.fire_code", 64'(err_code), 64'd2);
        check("tout.nwrites",   64'(wr_addr_q.size()), 64'd1);
        $display("seq    timeout boundary: error=%0d code=%0d", error, err_code);

        // ---- reset in the middle of DATA ----
        clear_writes();
        drive_byte(8'hA5, 0);
        drive_byte(8'h02, 0);
        drive_byte(8'h00, 0);
        drive_byte(8'h11, 0);
        drive_byte(8'h22, 0);
        drive_byte(8'h33, 0);
        drive_byte(8'h44, 0);
        drive_byte(8'h55, 0);
        drive_byte(8'h66, 0);
        do_reset();
        check_reset_state("midreset");
        clear_writes();
        drive_byte(8'hA5, 0);
        drive_byte(8'h01, 0);
        drive_byte(8'h00, 0);
        drive_byte(8'h77, 0);
        drive_byte(8'h88, 0);
        drive_byte(8'h99, 0);
        drive_byte(8'hAA, 0);
        drive_byte(8'h42, 0);
        cycle();
        check("midreset.nwrites", 64'(wr_addr_q.size()), 64'd1);
        if (wr_addr_q.size() > 0) begin
            check("midreset.w0_addr", 64'(wr_addr_q[0]), 64'd0);
            check("midreset.w0_data", 64'(wr_data_q[0]), 64'hAA998877);
        end
        check("midreset.done",  64'(done),         64'd1);
        check("midreset.words", 64'(words_loaded), 64'd1);
        $display("seq    reset mid-DATA then reload: done=%0d words=%0d", done, words_loaded);

        // ---- N = 2^ADDR_WIDTH is accepted ----
        drive_byte(8'hA5, 0);
        drive_byte(8'h00, 0);
        drive_byte(8'h01, 0);
        check("n256.error", 64'(error), 64'd0);
        check("n256.busy",  64'(busy),  64'd1);
        $display("seq    N=256 accepted: busy=%0d error=%0d", busy, error);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
